mmcm_reset_sequencer: RTL and testbench



---
 rtl/mmcm_reset_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_mmcm_reset_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_reset_sequencer.sv
// ---------------------------------------------------------------------------
// mmcm_reset_sequencer
//
// Purpose:
//   Holds the downstream clock domains in reset until the MMCM has reported a
//   stable lock. It then releases the per-domain resets one at a time, in
//   ascending bit order, with a fixed gap between releases. All resets are
//   re-asserted together on lock loss or on a software reset request. Lock
//   losses seen after release has started are counted for debug.
//
// Ports:
//   clk_i           in   1            generated clock, rising edge
//   rstn_i          in   1            asynchronous active-low reset
//   locked_i        in   1            MMCM LOCKED, asynchronous to clk_i
//   sw_rst_req_i    in   1            single-cycle software reset request
//   rst_n_o         out  NUM_DOMAINS  active-low domain resets, bit 0 first
//   all_released_o  out  1            high while every domain is released
//   state_o         out  3            FSM state encoding (debug)
//   lock_loss_cnt_o out  8            saturating lock-loss counter
//   lock_timeout_o  out  1            sticky lock-wait timeout flag
//
// Optional feature (macro RST_SEQ_LOCK_TIMEOUT_EN):
//   When defined, a 32-bit counter measures time spent in WAIT_LOCK and sets
//   lock_timeout_o once it reaches LOCK_TIMEOUT_CYCLES. The flag is status
//   only and clears only on rstn_i. When undefined, lock_timeout_o is 0.
// ---------------------------------------------------------------------------
module mmcm_reset_sequencer #(
    parameter int unsigned NUM_DOMAINS         = 3,
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   locked_i,
    input  logic                   sw_rst_req_i,
    output logic [NUM_DOMAINS-1:0] rst_n_o,
    output logic                   all_released_o,
    output logic [2:0]             state_o,
    output logic [7:0]             lock_loss_cnt_o,
    output logic                   lock_timeout_o
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    localparam logic [NUM_DOMAINS-1:0] LP_ALL_ONES = '1;
    localparam logic [NUM_DOMAINS-1:0] LP_FIRST    = NUM_DOMAINS'(1);
    localparam logic [31:0]            LP_STABLE   = 32'(LOCK_STABLE_CYCLES);
    localparam logic [31:0]            LP_GAP_LAST = 32'(STAGE_GAP_CYCLES - 1);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        LOCK_STABLE_CYCLES < 1 || STAGE_GAP_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mmcm_reset_sequencer: parameter out of legal range");
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;
    logic [31:0]            r_stable_cnt;
    logic [31:0]            w_stable_cnt_next;
    logic [31:0]            r_gap_cnt;
    logic [31:0]            w_gap_cnt_next;
    logic [NUM_DOMAINS-1:0] r_rst_n;
    logic [NUM_DOMAINS-1:0] w_rst_n_next;
    logic [NUM_DOMAINS-1:0] w_rst_n_shift;
    logic                   r_all_rel;
    logic                   w_all_rel_next;
    logic [7:0]             r_loss_cnt;
    logic [7:0]             w_loss_cnt_next;

    // Plain shift-register synchronizer; only its last stage is used.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked_i};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Releases fill from bit 0 upward, so the next pattern is a shift-in of 1.
    assign w_rst_n_shift = (r_rst_n << 1) | LP_FIRST;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_WAIT_LOCK;
            r_stable_cnt <= '0;
            r_gap_cnt    <= '0;
            r_rst_n      <= '0;
            r_all_rel    <= 1'b0;
            r_loss_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_stable_cnt <= w_stable_cnt_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_rst_n      <= w_rst_n_next;
            r_all_rel    <= w_all_rel_next;
            r_loss_cnt   <= w_loss_cnt_next;
        end
    end

    // Lock loss is tested before the software request so it wins when both
    // happen together. The gap counter also times the HOLD state.
    always_comb begin
        w_state_next      = r_state;
        w_stable_cnt_next = r_stable_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_rst_n_next      = r_rst_n;
        w_all_rel_next    = r_all_rel;
        w_loss_cnt_next   = r_loss_cnt;

        case (r_state)
            ST_WAIT_LOCK: begin
                w_rst_n_next      = '0;
                w_all_rel_next    = 1'b0;
                w_stable_cnt_next = '0;
                w_gap_cnt_next    = '0;
                if (w_locked_s) begin
                    w_state_next      = ST_STABLE;
                    w_stable_cnt_next = 32'd1;
                end
            end

            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_state_next      = ST_WAIT_LOCK;
                    w_stable_cnt_next = '0;
                end else if (r_stable_cnt == LP_STABLE) begin
                    w_stable_cnt_next = '0;
                    w_gap_cnt_next    = '0;
                    if (NUM_DOMAINS == 1) begin
                        w_state_next   = ST_RUN;
                        w_rst_n_next   = LP_ALL_ONES;
                        w_all_rel_next = 1'b1;
                    end else begin
                        w_state_next = ST_RELEASE;
                        w_rst_n_next = LP_FIRST;
                    end
                end else begin
                    w_stable_cnt_next = r_stable_cnt + 32'd1;
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_next   = ST_WAIT_LOCK;
                    w_rst_n_next   = '0;
                    w_all_rel_next = 1'b0;
                    w_gap_cnt_next = '0;
                    if (r_loss_cnt != 8'hFF) begin
                        w_loss_cnt_next = r_loss_cnt + 8'd1;
                    end
                end else if (sw_rst_req_i) begin
                    w_state_next   = ST_HOLD;
                    w_rst_n_next   = '0;
                    w_all_rel_next = 1'b0;
                    w_gap_cnt_next = '0;
                end else if (r_state == ST_RELEASE) begin
                    if (r_gap_cnt == LP_GAP_LAST) begin
                        w_gap_cnt_next = '0;
                        w_rst_n_next   = w_rst_n_shift;
                        if (w_rst_n_shift == LP_ALL_ONES) begin
                            w_state_next   = ST_RUN;
                            w_all_rel_next = 1'b1;
                        end
                    end else begin
                        w_gap_cnt_next = r_gap_cnt + 32'd1;
                    end
                end
            end

            ST_HOLD: begin
                if (!w_locked_s) begin
                    w_state_next   = ST_WAIT_LOCK;
                    w_gap_cnt_next = '0;
                end else if (r_gap_cnt == LP_GAP_LAST) begin
                    w_state_next      = ST_STABLE;
                    w_stable_cnt_next = 32'd1;
                    w_gap_cnt_next    = '0;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 32'd1;
                end
            end

            default: begin
                w_state_next      = ST_WAIT_LOCK;
                w_rst_n_next      = '0;
                w_all_rel_next    = 1'b0;
                w_stable_cnt_next = '0;
                w_gap_cnt_next    = '0;
            end
        endcase
    end

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    logic [31:0] r_timeout_cnt;
    logic        r_timeout_flag;

    // Counts only while staying in WAIT_LOCK; saturates at the limit so the
    // flag cannot be re-triggered by a wrap.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_timeout_cnt  <= '0;
            r_timeout_flag <= 1'b0;
        end else if (r_state == ST_WAIT_LOCK && w_state_next == ST_WAIT_LOCK) begin
            if (r_timeout_cnt != 32'(LOCK_TIMEOUT_CYCLES)) begin
                r_timeout_cnt <= r_timeout_cnt + 32'd1;
            end
            if (r_timeout_cnt == 32'(LOCK_TIMEOUT_CYCLES - 1)) begin
                r_timeout_flag <= 1'b1;
            end
        end else begin
            r_timeout_cnt <= '0;
        end
    end

    assign lock_timeout_o = r_timeout_flag;
`else
    assign lock_timeout_o = 1'b0;
`endif

    assign rst_n_o         = r_rst_n;
    assign all_released_o  = r_all_rel;
    assign state_o         = r_state;
    assign lock_loss_cnt_o = r_loss_cnt;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mmcm_reset_sequencer
//
// Self-checking bench for mmcm_reset_sequencer. A behavioural model tracks
// when stability began and derives the released-domain count from elapsed
// edges; each scenario task compares the DUT against it and against fixed
// expectations for the documented timing points.
// ---------------------------------------------------------------------------
module tb_mmcm_reset_sequencer;

    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int GAP  = 4;
    localparam int TMO  = 20;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic           locked_i;
    logic           sw_rst_req_i;
    logic [N-1:0]   rst_n_o;
    logic           all_released_o;
    logic [2:0]     state_o;
    logic [7:0]     lock_loss_cnt_o;
    logic           lock_timeout_o;

    int checks   = 0;
    int failures = 0;

    int           edgeNo;
    bit           pipe [SYNC];
    bit           mWaiting;
    bit           mHolding;
    int           mStableStart;
    int           mHoldStart;
    int           mLoss;
    int           waitRun;
    bit           mFlag;
    logic [N-1:0] expRst;
    logic         expAll;
    logic [2:0]   expState;

    mmcm_reset_sequencer #(
        .NUM_DOMAINS        (N),
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_GAP_CYCLES   (GAP),
        .LOCK_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .locked_i       (locked_i),
        .sw_rst_req_i   (sw_rst_req_i),
        .rst_n_o        (rst_n_o),
        .all_released_o (all_released_o),
        .state_o        (state_o),
        .lock_loss_cnt_o(lock_loss_cnt_o),
        .lock_timeout_o (lock_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [N+12:0] dutVec();
        return {rst_n_o, all_released_o, state_o, lock_loss_cnt_o, lock_timeout_o};
    endfunction

    function automatic logic [N+12:0] expVec();
        return {expRst, expAll, expState, 8'(mLoss), mFlag};
    endfunction

    // Outputs follow from how many edges have passed since stability began.
    function automatic void deriveExp();
        int elapsed;
        int k;
        if (mWaiting) begin
            expRst = '0; expAll = 1'b0; expState = 3'd0;
        end else if (mHolding) begin
            expRst = '0; expAll = 1'b0; expState = 3'd4;
        end else begin
            elapsed = edgeNo - mStableStart;
            if (elapsed < LSC) k = 0;
            else begin
                k = 1 + (elapsed - LSC) / GAP;
                if (k > N) k = N;
            end
            expRst   = N'((1 << k) - 1);
            expAll   = (k == N);
            expState = (k == 0) ? 3'd1 : ((k < N) ? 3'd2 : 3'd3);
        end
    endfunction

    function automatic void modelReset();
        edgeNo = 0;
        for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
        mWaiting = 1'b1; mHolding = 1'b0;
        mStableStart = 0; mHoldStart = 0;
        mLoss = 0; waitRun = 0; mFlag = 1'b0;
        deriveExp();
    endfunction

    // Advances DUT and model by one rising edge, returning at the next falling edge.
    task automatic tick();
        bit         ls;
        bit         sw;
        logic [2:0] prevState;
        @(posedge clk_i);
        edgeNo++;
        ls = pipe[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]   = locked_i;
        sw        = sw_rst_req_i;
        prevState = expState;
        case (prevState)
            3'd0: if (ls) begin mWaiting = 1'b0; mStableStart = edgeNo; end
            3'd1: if (!ls) mWaiting = 1'b1;
            3'd2, 3'd3: begin
                if (!ls) begin
                    mWaiting = 1'b1;
                    if (mLoss < 255) mLoss++;
                end else if (sw) begin
                    mHolding = 1'b1; mHoldStart = edgeNo;
                end
            end
            3'd4: begin
                if (!ls) begin
                    mWaiting = 1'b1; mHolding = 1'b0;
                end else if (edgeNo - mHoldStart == GAP) begin
                    mHolding = 1'b0; mStableStart = edgeNo;
                end
            end
            default: mWaiting = 1'b1;
        endcase
        deriveExp();
        if (prevState == 3'd0 && expState == 3'd0) begin
            if (waitRun < TMO) waitRun++;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
            if (waitRun == TMO) mFlag = 1'b1;
`endif
        end else begin
            waitRun = 0;
        end
        @(negedge clk_i);
    endtask

    task automatic applyReset(input bit lockVal);
        @(negedge clk_i);
        rstn_i       = 1'b0;
        sw_rst_req_i = 1'b0;
        locked_i     = lockVal;
        modelReset();
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; locked_i = 1'b0; sw_rst_req_i = 1'b0;
        modelReset();
        repeat (2) @(negedge clk_i);
        checks++; if (rst_n_o !== 3'b000) begin failures++; $display("FAIL reset_rst_n got=%b expected=000", rst_n_o); end
        checks++; if (all_released_o !== 1'b0) begin failures++; $display("FAIL reset_all_released got=%b expected=0", all_released_o); end
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d expected=0", state_o); end
        checks++; if (lock_loss_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_loss_cnt got=%0d expected=0", lock_loss_cnt_o); end
        checks++; if (lock_timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b expected=0", lock_timeout_o); end
    endtask

    task automatic test_power_up();
        logic [2:0] want;
        applyReset(1'b1);
        for (int e = 1; e <= 19; e++) begin
            tick();
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL powerup_model edge=%0d got=%h expected=%h", edgeNo, dutVec(), expVec()); end
            if (e == 10 || e == 11 || e == 14 || e == 15 || e == 18 || e == 19) begin
                want = (e < 11) ? 3'b000 : (e < 15) ? 3'b001 : (e < 19) ? 3'b011 : 3'b111;
                checks++;
                if (rst_n_o !== want) begin failures++; $display("FAIL powerup_rst_n edge=%0d got=%b expected=%b", e, rst_n_o, want); end
            end
        end
        checks++;
        if (all_released_o !== 1'b1 || state_o !== 3'd3) begin
            failures++; $display("FAIL powerup_run got all=%b state=%0d expected all=1 state=3", all_released_o, state_o);
        end
    endtask

    task automatic test_sw_reset();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        checks++;
        if (state_o !== 3'd4 || rst_n_o !== 3'b000) begin failures++; $display("FAIL swrst_enter got state=%0d rst=%b expected state=4 rst=000", state_o, rst_n_o); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (state_o !== 3'd4) begin failures++; $display("FAIL swrst_hold cycle=%0d got=%0d expected=4", i, state_o); end
        end
        tick();
        checks++;
        if (state_o !== 3'd1) begin failures++; $display("FAIL swrst_stable got=%0d expected=1", state_o); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (rst_n_o[0] !== (i == 8)) begin failures++; $display("FAIL swrst_release step=%0d got=%b expected=%b", i, rst_n_o[0], (i == 8)); end
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL swrst_model edge=%0d got=%h expected=%h", edgeNo, dutVec(), expVec()); end
        end
    endtask

    task automatic test_sw_and_loss();
        int n;
        n = 0;
        while (expState != 3'd3 && n < 100) begin
            tick(); n++;
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL simul_model edge=%0d got=%h expected=%h", edgeNo, dutVec(), expVec()); end
        end
        locked_i = 1'b0;
        tick();
        tick();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        checks++;
        if (state_o !== 3'd0) begin failures++; $display("FAIL simul_state got=%0d expected=0", state_o); end
        checks++;
        if (lock_loss_cnt_o !== 8'd1) begin failures++; $display("FAIL simul_loss_cnt got=%0d expected=1", lock_loss_cnt_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (state_o !== 3'd0) begin failures++; $display("FAIL simul_no_hold cycle=%0d got=%0d expected=0", i, state_o); end
        end
    endtask

    task automatic test_lock_loss();
        int n;
        for (int r = 0; r < 300; r++) begin
            locked_i = 1'b1;
            n = 0;
            while (expState != 3'd3 && n < 100) begin
                tick(); n++;
                checks++;
                if (dutVec() !== expVec()) begin failures++; $display("FAIL loss_model iter=%0d edge=%0d got=%h expected=%h", r, edgeNo, dutVec(), expVec()); end
            end
            locked_i = 1'b0;
            tick();
            tick();
            if (r == 0) begin
                checks++;
                if (rst_n_o !== 3'b111) begin failures++; $display("FAIL loss_early got=%b expected=111", rst_n_o); end
            end
            tick();
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL loss_drop iter=%0d got=%h expected=%h", r, dutVec(), expVec()); end
            if (r == 0) begin
                checks++;
                if (rst_n_o !== 3'b000 || lock_loss_cnt_o !== 8'd2) begin
                    failures++; $display("FAIL loss_first got rst=%b cnt=%0d expected rst=000 cnt=2", rst_n_o, lock_loss_cnt_o);
                end
            end
        end
        checks++;
        if (lock_loss_cnt_o !== 8'd255) begin failures++; $display("FAIL loss_saturate got=%0d expected=255", lock_loss_cnt_o); end
    endtask

    task automatic test_stable_glitch();
        bit seenWait;
        int n;
        applyReset(1'b1);
        seenWait = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL glitch_pre edge=%0d got=%h expected=%h", edgeNo, dutVec(), expVec()); end
        end
        locked_i = 1'b0;
        repeat (3) tick();
        locked_i = 1'b1;
        n = 0;
        while ((expState != 3'd3 || n == 0) && n < 100) begin
            tick(); n++;
            if (state_o === 3'd0) seenWait = 1'b1;
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL glitch_model edge=%0d got=%h expected=%h", edgeNo, dutVec(), expVec()); end
            if (edgeNo == 19 || edgeNo == 20 || edgeNo == 28) begin
                checks++;
                if (rst_n_o !== ((edgeNo == 19) ? 3'b000 : (edgeNo == 20) ? 3'b001 : 3'b111)) begin
                    failures++; $display("FAIL glitch_timing edge=%0d got=%b", edgeNo, rst_n_o);
                end
            end
        end
        checks++;
        if (seenWait !== 1'b1) begin failures++; $display("FAIL glitch_wait got=%b expected=1", seenWait); end
        checks++;
        if (lock_loss_cnt_o !== 8'd0) begin failures++; $display("FAIL glitch_loss_cnt got=%0d expected=0", lock_loss_cnt_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            locked_i     = ($urandom_range(0, 99) < 97);
            sw_rst_req_i = ($urandom_range(0, 99) < 3);
            tick();
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL random_model step=%0d edge=%0d got=%h expected=%h", i, edgeNo, dutVec(), expVec()); end
        end
        sw_rst_req_i = 1'b0;
    endtask

    task automatic test_timeout_async();
        logic flagLate;
        int n;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
        flagLate = 1'b1;
`else
        flagLate = 1'b0;
`endif
        applyReset(1'b0);
        for (int e = 1; e <= 24; e++) begin
            tick();
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL timeout_model edge=%0d got=%h expected=%h", edgeNo, dutVec(), expVec()); end
            if (e == 19 || e == 20) begin
                checks++;
                if (lock_timeout_o !== ((e == 20) ? flagLate : 1'b0)) begin
                    failures++; $display("FAIL timeout_edge edge=%0d got=%b", e, lock_timeout_o);
                end
            end
        end
        locked_i = 1'b1;
        n = 0;
        while (expState != 3'd2 && n < 100) begin
            tick(); n++;
            checks++;
            if (dutVec() !== expVec()) begin failures++; $display("FAIL timeout_relock edge=%0d got=%h expected=%h", edgeNo, dutVec(), expVec()); end
        end
        tick();
        checks++;
        if (state_o !== 3'd2 || lock_timeout_o !== flagLate) begin
            failures++; $display("FAIL timeout_sticky got state=%0d flag=%b expected state=2 flag=%b", state_o, lock_timeout_o, flagLate);
        end
        #3;
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({rst_n_o, all_released_o, state_o, lock_loss_cnt_o, lock_timeout_o} !== '0) begin
            failures++; $display("FAIL async_reset got rst=%b all=%b state=%0d cnt=%0d flag=%b expected all zero",
                                 rst_n_o, all_released_o, state_o, lock_loss_cnt_o, lock_timeout_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    initial begin
        $display("[TB] mmcm_reset_sequencer bench start");
        test_reset();
        test_power_up();
        test_sw_reset();
        test_sw_and_loss();
        test_lock_loss();
        test_stable_glitch();
        test_random();
        test_timeout_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
